regfile_wb_buffer: RTL and testbench
====================================

Name: regfile_wb_buffer

Overview:
- Write-side initiator for the 32x32 register bank: drives the bank's din / wa / rw write port.
- Accepts register-write requests from the execute/memory stages through a valid/ready handshake and queues them in a small in-order FIFO.
- Drains at most one write per cycle to the bank.
- Provides read-address forwarding so consumers see pending writes before they land in the bank.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  write request valid.
- in_ready  out  1  buffer can accept; equals !full.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  write data.
- drain_hold  in  1  when high, no new write is issued to the bank this cycle.
- wr_en  out  1  to bank rw; registered.
- wr_addr  out  ADDR_W  to bank wa; registered.
- wr_data  out  DATA_W  to bank din; registered.
- ra1  in  ADDR_W  read address 1, same value the bank sees.
- ra2  in  ADDR_W  read address 2.
- fwd1_hit  out  1  a pending write to ra1 exists.
- fwd1_data  out  DATA_W  youngest pending data for ra1; 0 when no hit.
- fwd2_hit  out  1  a pending write to ra2 exists.
- fwd2_data  out  DATA_W  youngest pending data for ra2; 0 when no hit.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset values: all outputs registered or derived; on rst: wr_en=0, wr_addr=0, wr_data=0, count=0, empty=1, full=0, in_ready=0 during the reset cycle, all fwd outputs=0. FIFO contents are don't-care but marked invalid.
- Reset mid-operation: pending entries are discarded, not written. A write presented on wr_* in the reset cycle is dropped: wr_en is forced to 0 that cycle's next edge.
- Push: in_valid & in_ready at a rising edge enqueues {in_addr, in_data} at the tail.
- Pop: at a rising edge, if !empty & !drain_hold, the head is dequeued into wr_addr/wr_data and wr_en=1 for exactly the following cycle. Otherwise wr_en=0 next cycle.
- Latency: a request pushed at edge N into an empty buffer appears on wr_* during cycle N+1 to N+2 (one cycle in the FIFO), so wr_en is high from edge N+1.
- Order: strictly FIFO, no coalescing. Two writes to the same register both reach the bank, oldest first.
- Simultaneous push and pop: both occur and count is unchanged. When full, in_ready=0 even if a pop happens that cycle; there is no combinational ready-from-pop path.
- Pointers: head/tail are ADDR of $clog2(DEPTH) bits and wrap modulo DEPTH. count disambiguates full from empty.
- Forwarding search set: all valid FIFO entries, plus the output register while wr_en=1. The output register is oldest and the FIFO tail is youngest. Youngest match wins.
- Forwarding is combinational from ra1/ra2 and registered state only. A request being pushed in the current cycle is not visible until the next cycle.
- Register 0 is an ordinary register (the bank has no hard-wired zero) and is forwarded like any other.
- drain_hold high with a full FIFO: in_ready stays 0 and the contents hold. Forwarding remains valid.

Decomposition:
- Shared package regfile_pkg holds: REG_ADDR_W=5, REG_DATA_W=32, REG_COUNT=32, and the struct wb_req_t {addr, data}.
- One natural sub-module, wb_fwd_match: a priority match of one read address against the entry array and valid/age ordering, returning hit and data. It is instantiated twice, for ra1 and ra2.
- The FIFO storage and pointers stay in the top module.

Test Plan:
- Reset then idle: assert rst for 2 cycles with in_valid=1 -> wr_en=0, count=0, empty=1, in_ready=0 during reset, no bank write.
- Single write: push {addr=3, data=0x1234} -> wr_en=1, wr_addr=3, wr_data=0x1234 exactly one cycle later, for one cycle. ra1=3 gives fwd1_hit=1, data 0x1234 while pending, then 0 after the write cycle.
- Fill and backpressure: drain_hold=1, push 4 writes (addr 1..4, data 10..40) -> full=1, in_ready=0, and a 5th request is not accepted. Release drain_hold -> writes emerge in order 1,2,3,4 on consecutive cycles.
- Forwarding priority: hold, push {5,100} then {5,200}; ra1=5, ra2=6 -> fwd1_hit=1 with fwd1_data=200, fwd2_hit=0 with fwd2_data=0. After the first drains, fwd1_data is still 200.
- Simultaneous push/pop at count=2 -> count stays 2 and order is preserved. Continuous push every cycle with no hold -> count ≤1 steady state and one write per cycle.
- Reset mid-drain: with 3 entries pending and wr_en=1, assert rst -> next cycle wr_en=0 and count=0. Entries never reach the bank.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-bank definitions for the write-back path.
// The write request struct pairs a destination register with its data.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Priority match of one read address against an age-ordered list of pending writes.
// Slot 0 is the oldest entry and slot N-1 the youngest; the youngest valid match wins.
module wb_fwd_match
  import regfile_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [REG_ADDR_W-1:0] ra,
  input  wb_req_t [N-1:0]       slots,
  input  logic [N-1:0]          slot_valid,
  output logic                  hit,
  output logic [REG_DATA_W-1:0] data
);

  // Ascending scan so a later (younger) match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (slot_valid[i] && (slots[i].addr == ra)) begin
        hit  = 1'b1;
        data = slots[i].data;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_buffer.sv
// In-order write-back buffer feeding the register bank write port, one write per cycle,
// with read-address forwarding of writes that have not yet landed in the bank.
module regfile_wb_buffer
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    drain_hold,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  input  logic [ADDR_W-1:0]       ra1,
  input  logic [ADDR_W-1:0]       ra2,
  output logic                    fwd1_hit,
  output logic [DATA_W-1:0]       fwd1_data,
  output logic                    fwd2_hit,
  output logic [DATA_W-1:0]       fwd2_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NSLOT = DEPTH + 1;

  wb_req_t            mem_q [DEPTH];
  wb_req_t            mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic               push;
  logic               pop;
  wb_req_t            push_req;
  wb_req_t [NSLOT-1:0] slots;
  logic [NSLOT-1:0]   slot_valid;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign in_ready = !full && !rst;
  assign count    = count_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

  assign push          = in_valid && in_ready;
  assign pop           = !empty && !drain_hold;
  assign push_req.addr = in_addr;
  assign push_req.data = in_data;

  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (push) begin
      mem_d[tail_q] = push_req;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d    = head_q + 1'b1;
      wr_en_d   = 1'b1;
      wr_addr_d = mem_q[head_q].addr;
      wr_data_d = mem_q[head_q].data;
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Age-ordered search list: output register first, then FIFO from head to tail.
  always_comb begin
    slots[0].addr = wr_addr_q;
    slots[0].data = wr_data_q;
    slot_valid[0] = wr_en_q;
    for (int k = 0; k < DEPTH; k++) begin
      slots[k+1]      = mem_q[head_q + PTR_W'(k)];
      slot_valid[k+1] = (CNT_W'(k) < count_q);
    end
  end

  wb_fwd_match #(.N(NSLOT)) u_fwd1 (
    .ra         (ra1),
    .slots      (slots),
    .slot_valid (slot_valid),
    .hit        (fwd1_hit),
    .data       (fwd1_data)
  );

  wb_fwd_match #(.N(NSLOT)) u_fwd2 (
    .ra         (ra2),
    .slots      (slots),
    .slot_valid (slot_valid),
    .hit        (fwd2_hit),
    .data       (fwd2_data)
  );

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench for regfile_wb_buffer: directed scenarios plus a randomized run
// against a queue-based reference model of the pending write list.
module tb_regfile_wb_buffer;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_hold;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int tests_run;
  int tests_failed;

  wb_req_t     model_q[$];
  logic        exp_wr_en;
  logic [4:0]  exp_wr_addr;
  logic [31:0] exp_wr_data;

  regfile_wb_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .drain_hold (drain_hold),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ra1        (ra1),
    .ra2        (ra2),
    .fwd1_hit   (fwd1_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_hit   (fwd2_hit),
    .fwd2_data  (fwd2_data),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and update the reference model with the inputs held across it.
  task automatic step();
    bit      do_push;
    bit      do_pop;
    wb_req_t head;
    wb_req_t req;
    do_push = in_valid && !rst && (model_q.size() < DEPTH);
    do_pop  = !rst && (model_q.size() > 0) && !drain_hold;
    req.addr = in_addr;
    req.data = in_data;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      exp_wr_en   = 1'b0;
      exp_wr_addr = '0;
      exp_wr_data = '0;
    end else begin
      exp_wr_en = 1'b0;
      if (do_pop) begin
        head        = model_q.pop_front();
        exp_wr_en   = 1'b1;
        exp_wr_addr = head.addr;
        exp_wr_data = head.data;
      end
      if (do_push) model_q.push_back(req);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
  endtask

  // Youngest pending write to ra: newest queue entry first, then the write on the bank port.
  function automatic void model_fwd(input logic [4:0] ra, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].addr == ra) begin
        hit = 1'b1;
        d   = model_q[i].data;
        return;
      end
    end
    if (exp_wr_en && exp_wr_addr == ra) begin
      hit = 1'b1;
      d   = exp_wr_data;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drain_hold = 1'b0;
    ra1 = 5'd0;
    ra2 = 5'd0;
    drive(1'b1, 5'd7, 32'hDEAD_BEEF);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if (wr_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wr_en: got %0b expected 0", wr_en); end
      tests_run++;
      if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL reset_count: got count=%0d empty=%0b full=%0b expected 0/1/0", count, empty, full);
      end
      tests_run++;
      if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin
        tests_failed++; $display("[TB] FAIL reset_wr_bus: got addr=%0d data=%h expected 0/0", wr_addr, wr_data);
      end
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready_hold: got %0b expected 0", in_ready); end
    end
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    ra1 = 5'd7;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_ready: got %0b expected 1", in_ready); end
    tests_run++;
    if (fwd1_hit !== 1'b0 || fwd1_data !== 32'd0) begin
      tests_failed++; $display("[TB] FAIL post_reset_fwd: got hit=%0b data=%h expected 0/0", fwd1_hit, fwd1_data);
    end
    step();
    tests_run++;
    if (wr_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_no_write: got %0b expected 0", wr_en); end
  endtask

  task automatic test_single_write();
    ra1 = 5'd3;
    drive(1'b1, 5'd3, 32'h1234);
    step();
    drive(1'b0, 5'd0, 32'd0);
    #1;
    tests_run++;
    if (wr_en !== 1'b0 || count !== 3'd1) begin
      tests_failed++; $display("[TB] FAIL single_queued: got wr_en=%0b count=%0d expected 0/1", wr_en, count);
    end
    tests_run++;
    if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h1234) begin
      tests_failed++; $display("[TB] FAIL single_fwd_fifo: got hit=%0b data=%h expected 1/1234", fwd1_hit, fwd1_data);
    end
    step();
    tests_run++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h1234) begin
      tests_failed++; $display("[TB] FAIL single_write: got en=%0b addr=%0d data=%h expected 1/3/1234", wr_en, wr_addr, wr_data);
    end
    tests_run++;
    if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h1234) begin
      tests_failed++; $display("[TB] FAIL single_fwd_out: got hit=%0b data=%h expected 1/1234", fwd1_hit, fwd1_data);
    end
    step();
    tests_run++;
    if (wr_en !== 1'b0 || fwd1_hit !== 1'b0 || fwd1_data !== 32'd0) begin
      tests_failed++; $display("[TB] FAIL single_done: got en=%0b hit=%0b data=%h expected 0/0/0", wr_en, fwd1_hit, fwd1_data);
    end
  endtask

  task automatic test_fill_backpressure();
    drain_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'(10 * i));
      step();
    end
    drive(1'b1, 5'd5, 32'd50);
    #1;
    tests_run++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
      tests_failed++; $display("[TB] FAIL fill_full: got full=%0b ready=%0b count=%0d expected 1/0/4", full, in_ready, count);
    end
    step();
    tests_run++;
    if (count !== 3'd4 || wr_en !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fill_reject: got count=%0d wr_en=%0b expected 4/0", count, wr_en);
    end
    drive(1'b0, 5'd0, 32'd0);
    drain_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests_run++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== 32'(10 * i)) begin
        tests_failed++; $display("[TB] FAIL fill_drain_order: got en=%0b addr=%0d data=%0d expected 1/%0d/%0d", wr_en, wr_addr, wr_data, i, 10 * i);
      end
    end
    step();
    tests_run++;
    if (wr_en !== 1'b0 || empty !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL fill_drained: got en=%0b empty=%0b expected 0/1", wr_en, empty);
    end
  endtask

  task automatic test_fwd_priority();
    drain_hold = 1'b1;
    drive(1'b1, 5'd5, 32'd100);
    step();
    drive(1'b1, 5'd5, 32'd200);
    step();
    drive(1'b0, 5'd0, 32'd0);
    ra1 = 5'd5;
    ra2 = 5'd6;
    #1;
    tests_run++;
    if (fwd1_hit !== 1'b1 || fwd1_data !== 32'd200) begin
      tests_failed++; $display("[TB] FAIL fwd_youngest: got hit=%0b data=%0d expected 1/200", fwd1_hit, fwd1_data);
    end
    tests_run++;
    if (fwd2_hit !== 1'b0 || fwd2_data !== 32'd0) begin
      tests_failed++; $display("[TB] FAIL fwd_miss: got hit=%0b data=%0d expected 0/0", fwd2_hit, fwd2_data);
    end
    drain_hold = 1'b0;
    step();
    tests_run++;
    if (wr_en !== 1'b1 || wr_data !== 32'd100 || fwd1_data !== 32'd200) begin
      tests_failed++; $display("[TB] FAIL fwd_after_drain: got wr_data=%0d fwd=%0d expected 100/200", wr_data, fwd1_data);
    end
    step();
    tests_run++;
    if (wr_data !== 32'd200 || fwd1_hit !== 1'b1 || fwd1_data !== 32'd200) begin
      tests_failed++; $display("[TB] FAIL fwd_out_reg: got wr_data=%0d hit=%0b fwd=%0d expected 200/1/200", wr_data, fwd1_hit, fwd1_data);
    end
    step();
    tests_run++;
    if (fwd1_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL fwd_cleared: got %0b expected 0", fwd1_hit); end
  endtask

  task automatic test_back_to_back();
    drain_hold = 1'b1;
    drive(1'b1, 5'd8, 32'd1);
    step();
    drive(1'b1, 5'd9, 32'd2);
    step();
    drain_hold = 1'b0;
    drive(1'b1, 5'd10, 32'd3);
    step();
    tests_run++;
    if (count !== 3'd2 || wr_en !== 1'b1 || wr_addr !== 5'd8) begin
      tests_failed++; $display("[TB] FAIL b2b_first: got count=%0d en=%0b addr=%0d expected 2/1/8", count, wr_en, wr_addr);
    end
    drive(1'b1, 5'd11, 32'd4);
    step();
    tests_run++;
    if (count !== 3'd2 || wr_addr !== 5'd9 || wr_data !== 32'd2) begin
      tests_failed++; $display("[TB] FAIL b2b_second: got count=%0d addr=%0d data=%0d expected 2/9/2", count, wr_addr, wr_data);
    end
    drive(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (wr_en !== 1'b1 || wr_addr !== 5'(10 + i) || wr_data !== 32'(3 + i)) begin
        tests_failed++; $display("[TB] FAIL b2b_order: got addr=%0d data=%0d expected %0d/%0d", wr_addr, wr_data, 10 + i, 3 + i);
      end
    end
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i), 32'(1000 + i));
      step();
      tests_run++;
      if (count > 3'd1) begin tests_failed++; $display("[TB] FAIL stream_count: got %0d expected <=1", count); end
      if (i > 0) begin
        tests_run++;
        if (wr_en !== 1'b1 || wr_addr !== 5'(i - 1) || wr_data !== 32'(999 + i)) begin
          tests_failed++; $display("[TB] FAIL stream_write: got en=%0b addr=%0d data=%0d expected 1/%0d/%0d", wr_en, wr_addr, wr_data, i - 1, 999 + i);
        end
      end
    end
    drive(1'b0, 5'd0, 32'd0);
    step();
    step();
  endtask

  task automatic test_reset_mid_drain();
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(20 + i), 32'(500 + i));
      step();
    end
    drive(1'b0, 5'd0, 32'd0);
    drain_hold = 1'b0;
    step();
    tests_run++;
    if (wr_en !== 1'b1 || count !== 3'd3) begin
      tests_failed++; $display("[TB] FAIL middrain_setup: got en=%0b count=%0d expected 1/3", wr_en, count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (wr_en !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL middrain_reset: got en=%0b count=%0d empty=%0b expected 0/0/1", wr_en, count, empty);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (wr_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL middrain_discard: got wr_en=%0b expected 0", wr_en); end
    end
  endtask

  task automatic test_random();
    logic        eh1, eh2;
    logic [31:0] ed1, ed2;
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 63) == 0);
      drain_hold = ($urandom_range(0, 9) < 3);
      drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 3)), $urandom);
      ra1 = 5'($urandom_range(0, 3));
      ra2 = 5'($urandom_range(0, 4));
      #1;
      model_fwd(ra1, eh1, ed1);
      model_fwd(ra2, eh2, ed2);
      tests_run++;
      if (in_ready !== (!rst && model_q.size() < DEPTH)) begin
        tests_failed++; $display("[TB] FAIL rand_ready: cycle %0d got %0b", c, in_ready);
      end
      tests_run++;
      if (fwd1_hit !== eh1 || fwd1_data !== ed1) begin
        tests_failed++; $display("[TB] FAIL rand_fwd1: cycle %0d got %0b/%h expected %0b/%h", c, fwd1_hit, fwd1_data, eh1, ed1);
      end
      tests_run++;
      if (fwd2_hit !== eh2 || fwd2_data !== ed2) begin
        tests_failed++; $display("[TB] FAIL rand_fwd2: cycle %0d got %0b/%h expected %0b/%h", c, fwd2_hit, fwd2_data, eh2, ed2);
      end
      step();
      tests_run++;
      if (wr_en !== exp_wr_en || count !== 3'(model_q.size()) || empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH)) begin
        tests_failed++; $display("[TB] FAIL rand_state: cycle %0d got en=%0b count=%0d expected en=%0b count=%0d", c, wr_en, count, exp_wr_en, model_q.size());
      end
      if (exp_wr_en) begin
        tests_run++;
        if (wr_addr !== exp_wr_addr || wr_data !== exp_wr_data) begin
          tests_failed++; $display("[TB] FAIL rand_write: cycle %0d got %0d/%h expected %0d/%h", c, wr_addr, wr_data, exp_wr_addr, exp_wr_data);
        end
      end
    end
    rst = 1'b0;
    drain_hold = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_wr_en    = 1'b0;
    exp_wr_addr  = '0;
    exp_wr_data  = '0;
    test_reset();
    test_single_write();
    test_fill_backpressure();
    test_fwd_priority();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
